// File: rtl/fifo_rd_stream.sv
// Read-domain consumer for the async FIFO: converts the 1-cycle-latency pop interface
// into a valid/ready stream through a 2-entry skid buffer, with flush and a word counter.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  r_rst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] d_out,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  words_out
);

  logic [DATA_WIDTH-1:0] r_buf0, r_buf1;
  logic [1:0]            r_occ;
  logic                  r_inflight, r_discard, r_mvalid;
  logic [CNT_WIDTH-1:0]  r_words;

  logic       w_pop, w_capture;
  logic [2:0] w_pending;
  logic [1:0] w_rem, w_occ_next;

  // Pop only when buffered words plus the word in flight still leave a free slot.
  always_comb begin
    w_pop      = r_mvalid & m_ready;
    w_pending  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    rd_en      = ~r_rst & ~flush & ~empty & (w_pending < 3'd2);
    w_capture  = r_inflight & ~r_discard & ~flush;
    w_rem      = r_occ - {1'b0, w_pop};
    w_occ_next = flush ? 2'd0 : (w_rem + {1'b0, w_capture});
  end

  always_ff @(posedge rd_clk) begin
    if (r_rst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_discard  <= 1'b0;
      r_mvalid   <= 1'b0;
      r_words    <= '0;
      r_buf0     <= '0;
    end else begin
      r_occ      <= w_occ_next;
      r_mvalid   <= (w_occ_next != 2'd0);
      r_inflight <= rd_en;
      r_discard  <= flush & r_inflight;
      r_words    <= r_words + {{(CNT_WIDTH-1){1'b0}}, w_pop};
      if (w_pop)
        r_buf0 <= r_buf1;
      if (w_capture && (w_rem == 2'd0))
        r_buf0 <= d_out;
    end
  end

  // Second slot carries data only; its contents are meaningless while occupancy < 2.
  always_ff @(posedge rd_clk) begin
    if (w_capture && (w_rem != 2'd0))
      r_buf1 <= d_out;
  end

  assign m_data    = r_buf0;
  assign m_valid   = r_mvalid;
  assign occupancy = r_occ;
  assign words_out = r_words;

endmodule
